// File: rtl/resp_sig_compactor.sv
// rtl/resp_sig_compactor.sv - folds accepted response vectors into a 32-bit MISR and checks it against a golden word.
// Optional X/Z detection on accepted samples is enabled by defining RESP_XCHK_EN (simulation only).
module resp_sig_compactor #(
  parameter int          OUT_W  = 330,
  parameter int          CYCLES = 100,
  parameter logic [31:0] POLY   = 32'h04C11DB7,
  parameter logic [31:0] SEED   = 32'hFFFFFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             resp_valid,
  input  logic [OUT_W-1:0] resp_data,
  input  logic [31:0]      expect_sig,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [31:0]      sig,
  output logic [31:0]      sample_cnt,
  output logic             x_seen
);

  localparam int NW = (OUT_W + 31) / 32;
  localparam int PW = NW * 32;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] sig_q, sig_d;
  logic [31:0] cnt_q, cnt_d;
  logic        pass_q, pass_d;
  logic        x_seen_q, x_seen_d;

  logic [PW-1:0] padded;
  logic [31:0]   fold;
  logic [31:0]   sig_next;
  logic          accept;
  logic          last;
  logic          x_in;

  // Zero-padded top word means the unused upper bits never disturb the fold.
  always_comb begin
    padded = '0;
    padded[OUT_W-1:0] = resp_data;
    fold = '0;
    for (int k = 0; k < NW; k++) begin
      fold = fold ^ padded[32*k +: 32];
    end
  end

  assign sig_next = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? POLY : 32'h0) ^ fold;
  assign accept   = (state_q == S_RUN) && resp_valid;
  assign last     = (cnt_q == 32'(CYCLES - 1));

`ifdef RESP_XCHK_EN
  assign x_in = ((^resp_data) === 1'bx);

  always_ff @(posedge clk) begin
    if (!rst && accept && x_in && !x_seen_q) begin
      $error("resp_sig_compactor: X/Z on resp_data at sample_cnt=%0d", cnt_q);
    end
  end
`else
  assign x_in = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    sig_d    = sig_q;
    cnt_d    = cnt_q;
    pass_d   = pass_q;
    x_seen_d = x_seen_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          sig_d    = SEED;
          cnt_d    = 32'd0;
          pass_d   = 1'b0;
          x_seen_d = 1'b0;
          if (CYCLES == 0) begin
            state_d = S_DONE;
            pass_d  = (SEED == expect_sig);
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (accept) begin
          sig_d    = sig_next;
          cnt_d    = cnt_q + 32'd1;
          x_seen_d = x_seen_q | x_in;
          if (last) begin
            state_d = S_DONE;
            pass_d  = (sig_next == expect_sig) && !x_seen_d;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sig_q    <= SEED;
      cnt_q    <= 32'd0;
      pass_q   <= 1'b0;
      x_seen_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sig_q    <= sig_d;
      cnt_q    <= cnt_d;
      pass_q   <= pass_d;
      x_seen_q <= x_seen_d;
    end
  end

  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign pass       = pass_q;
  assign sig        = sig_q;
  assign sample_cnt = cnt_q;
  assign x_seen     = x_seen_q;

endmodule

// File: tb/tb_resp_sig_compactor.sv
// tb/tb_resp_sig_compactor.sv - vector table, hand sequences and randomized runs against a signature model.
module tb_resp_sig_compactor;

  localparam int          OW   = 330;
  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] SEED = 32'hFFFFFFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [OW-1:0] resp_data;
  logic [31:0]   expect_sig;

  logic start1, start3, start100, start0;
  logic v1, v3, v100, v0;
  logic busy1, busy3, busy100, busy0;
  logic done1, done3, done100, done0;
  logic pass1, pass3, pass100, pass0;
  logic x1, x3, x100, x0;
  logic [31:0] sig1, sig3, sig100, sig0;
  logic [31:0] cnt1, cnt3, cnt100, cnt0;

  resp_sig_compactor #(.OUT_W(OW), .CYCLES(1), .POLY(POLY), .SEED(SEED)) u1 (
    .clk(clk), .rst(rst), .start(start1), .resp_valid(v1), .resp_data(resp_data),
    .expect_sig(expect_sig), .busy(busy1), .done(done1), .pass(pass1), .sig(sig1),
    .sample_cnt(cnt1), .x_seen(x1));
  resp_sig_compactor #(.OUT_W(OW), .CYCLES(3), .POLY(POLY), .SEED(SEED)) u3 (
    .clk(clk), .rst(rst), .start(start3), .resp_valid(v3), .resp_data(resp_data),
    .expect_sig(expect_sig), .busy(busy3), .done(done3), .pass(pass3), .sig(sig3),
    .sample_cnt(cnt3), .x_seen(x3));
  resp_sig_compactor #(.OUT_W(OW), .CYCLES(100), .POLY(POLY), .SEED(SEED)) u100 (
    .clk(clk), .rst(rst), .start(start100), .resp_valid(v100), .resp_data(resp_data),
    .expect_sig(expect_sig), .busy(busy100), .done(done100), .pass(pass100), .sig(sig100),
    .sample_cnt(cnt100), .x_seen(x100));
  resp_sig_compactor #(.OUT_W(OW), .CYCLES(0), .POLY(POLY), .SEED(SEED)) u0 (
    .clk(clk), .rst(rst), .start(start0), .resp_valid(v0), .resp_data(resp_data),
    .expect_sig(expect_sig), .busy(busy0), .done(done0), .pass(pass0), .sig(sig0),
    .sample_cnt(cnt0), .x_seen(x0));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: XOR of 32-bit chunks of the zero-extended vector, then one Galois MISR shift.
  function automatic logic [31:0] fold_of(input logic [OW-1:0] d);
    logic [351:0] t;
    logic [31:0]  f;
    t = {22'b0, d};
    f = 32'h0;
    for (int k = 0; k < 11; k++) begin
      f = f ^ t[31:0];
      t = t >> 32;
    end
    return f;
  endfunction

  function automatic logic [31:0] step(input logic [31:0] s, input logic [OW-1:0] d);
    logic [32:0] dbl;
    dbl = {s, 1'b0};
    return dbl[31:0] ^ (dbl[32] ? POLY : 32'h0) ^ fold_of(d);
  endfunction

  function automatic logic [OW-1:0] rand_vec();
    logic [OW-1:0] d;
    d = '0;
    for (int k = 0; k < 11; k++) d = {d[OW-33:0], 32'($urandom)};
    return d;
  endfunction

  task automatic set_start(input int w, input logic v);
    case (w)
      3:       start3 = v;
      100:     start100 = v;
      default: start1 = v;
    endcase
  endtask

  task automatic set_valid(input int w, input logic v);
    case (w)
      3:       v3 = v;
      100:     v100 = v;
      default: v1 = v;
    endcase
  endtask

  function automatic logic get_done(input int w);
    return (w == 3) ? done3 : (w == 100) ? done100 : done1;
  endfunction
  function automatic logic get_busy(input int w);
    return (w == 3) ? busy3 : (w == 100) ? busy100 : busy1;
  endfunction
  function automatic logic get_pass(input int w);
    return (w == 3) ? pass3 : (w == 100) ? pass100 : pass1;
  endfunction
  function automatic logic [31:0] get_sig(input int w);
    return (w == 3) ? sig3 : (w == 100) ? sig100 : sig1;
  endfunction
  function automatic logic [31:0] get_cnt(input int w);
    return (w == 3) ? cnt3 : (w == 100) ? cnt100 : cnt1;
  endfunction

  task automatic run_rand(input int w, input int ncyc, input bit good, input int pv);
    logic [31:0]   ms, nx;
    logic [OW-1:0] d;
    int            n, budget;
    logic          v;
    ms = SEED;
    n = 0;
    budget = ncyc * 20 + 50;
    expect_sig = $urandom;
    set_start(w, 1'b1);
    tick;
    set_start(w, 1'b0);
    chk1("run_busy", get_busy(w), 1'b1);
    chk("run_seed", get_sig(w), SEED);
    while (!get_done(w) && budget > 0) begin
      d = rand_vec();
      v = ($urandom_range(0, 99) < pv);
      resp_data = d;
      set_valid(w, v);
      if (v) begin
        nx = step(ms, d);
        if (n == ncyc - 1) expect_sig = good ? nx : ~nx;
        ms = nx;
        n++;
      end
      tick;
      budget--;
    end
    set_valid(w, 1'b0);
    chk1("run_done", get_done(w), 1'b1);
    chk("run_sig", get_sig(w), ms);
    chk("run_cnt", get_cnt(w), 32'(n));
    chk1("run_pass", get_pass(w), good);
  endtask

  typedef struct {
    logic [OW-1:0] data;
    logic [31:0]   exp_in;
    logic [31:0]   sig;
    logic          pass;
  } vec_t;

  vec_t          tv[6];
  logic [OW-1:0] tmp;
  logic [31:0]   ms;
  int            n;
  logic          pat[5];

  initial begin
    rst = 1'b1;
    resp_data = '0;
    expect_sig = 32'h0;
    {start1, start3, start100, start0} = 4'b0;
    {v1, v3, v100, v0} = 4'b0;
    tick;
    tick;

    chk("rst_sig1", sig1, SEED);
    chk("rst_sig100", sig100, SEED);
    chk("rst_cnt3", cnt3, 32'd0);
    chk1("rst_busy100", busy100, 1'b0);
    chk1("rst_done1", done1, 1'b0);
    chk1("rst_done0", done0, 1'b0);
    chk1("rst_pass3", pass3, 1'b0);
    chk1("rst_x100", x100, 1'b0);
    rst = 1'b0;
    tick;
    chk1("idle_busy1", busy1, 1'b0);

    tmp = '0; tmp[329] = 1'b1;
    tv[0] = '{'0, 32'hFB3EE249, 32'hFB3EE249, 1'b1};
    tv[1] = '{'0, 32'h00000000, 32'hFB3EE249, 1'b0};
    tv[2] = '{330'h1, 32'hFB3EE249, 32'hFB3EE248, 1'b0};
    tv[3] = '{330'h1_00000001, 32'hFB3EE249, 32'hFB3EE249, 1'b1};
    tv[4] = '{tmp, 32'hFB3EE049, 32'hFB3EE049, 1'b1};
    tmp = rand_vec();
    tv[5] = '{tmp, step(SEED, tmp), step(SEED, tmp), 1'b1};

    for (int i = 0; i < 6; i++) begin
      resp_data = tv[i].data;
      expect_sig = tv[i].exp_in;
      start1 = 1'b1;
      tick;
      start1 = 1'b0;
      chk1($sformatf("tv%0d_busy", i), busy1, 1'b1);
      chk1($sformatf("tv%0d_notdone", i), done1, 1'b0);
      chk($sformatf("tv%0d_seed", i), sig1, SEED);
      v1 = 1'b1;
      tick;
      v1 = 1'b0;
      chk($sformatf("tv%0d_sig", i), sig1, tv[i].sig);
      chk1($sformatf("tv%0d_pass", i), pass1, tv[i].pass);
      chk1($sformatf("tv%0d_done", i), done1, 1'b1);
      chk1($sformatf("tv%0d_idlebusy", i), busy1, 1'b0);
      chk($sformatf("tv%0d_cnt", i), cnt1, 32'd1);
    end
    resp_data = rand_vec();
    v1 = 1'b1;
    tick;
    tick;
    v1 = 1'b0;
    chk("done_hold_cnt", cnt1, 32'd1);
    chk("done_hold_sig", sig1, tv[5].sig);
    chk1("done_hold_pass", pass1, 1'b1);

    // Stall pattern with an ignored mid-run start.
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    start3 = 1'b1;
    tick;
    start3 = 1'b0;
    chk1("s3_busy", busy3, 1'b1);
    ms = SEED;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      resp_data = rand_vec();
      v3 = pat[i];
      start3 = (i == 1);
      if (pat[i]) begin
        ms = step(ms, resp_data);
        n++;
      end
      expect_sig = ms;
      tick;
      chk($sformatf("s3_cnt%0d", i), cnt3, 32'(n));
      chk1($sformatf("s3_done%0d", i), done3, (i == 4));
      chk($sformatf("s3_sig%0d", i), sig3, ms);
    end
    v3 = 1'b0;
    start3 = 1'b0;
    chk1("s3_pass", pass3, 1'b1);
    v3 = 1'b1;
    tick;
    v3 = 1'b0;
    chk("s3_cnt_cap", cnt3, 32'd3);
    start3 = 1'b1;
    tick;
    start3 = 1'b0;
    chk("s3_restart_sig", sig3, SEED);
    chk("s3_restart_cnt", cnt3, 32'd0);
    chk1("s3_restart_pass", pass3, 1'b0);
    chk1("s3_restart_done", done3, 1'b0);
    chk1("s3_restart_busy", busy3, 1'b1);
    v3 = 1'b1;
    resp_data = '0;
    expect_sig = 32'h0;
    repeat (3) tick;
    v3 = 1'b0;
    chk1("s3_run2_done", done3, 1'b1);

    for (int r = 0; r < 6; r++) run_rand(3, 3, (r % 2) == 0, 60);
    run_rand(100, 100, 1'b1, 75);
    run_rand(100, 100, 1'b0, 90);

    // Reset two samples into a 100-sample run.
    start100 = 1'b1;
    tick;
    start100 = 1'b0;
    v100 = 1'b1;
    resp_data = rand_vec();
    tick;
    tick;
    chk("mid_cnt", cnt100, 32'd2);
    rst = 1'b1;
    start100 = 1'b1;
    tick;
    rst = 1'b0;
    start100 = 1'b0;
    chk1("mid_busy", busy100, 1'b0);
    chk1("mid_done", done100, 1'b0);
    chk("mid_sig", sig100, SEED);
    chk("mid_cnt0", cnt100, 32'd0);
    tick;
    v100 = 1'b0;
    chk1("mid_idle", busy100, 1'b0);
    chk("mid_idle_cnt", cnt100, 32'd0);

    // Zero-length runs finish on the start edge.
    expect_sig = SEED;
    v0 = 1'b1;
    start0 = 1'b1;
    tick;
    start0 = 1'b0;
    chk1("c0_done", done0, 1'b1);
    chk1("c0_busy", busy0, 1'b0);
    chk("c0_sig", sig0, SEED);
    chk1("c0_pass", pass0, 1'b1);
    chk("c0_cnt", cnt0, 32'd0);
    expect_sig = 32'h0;
    start0 = 1'b1;
    tick;
    start0 = 1'b0;
    v0 = 1'b0;
    chk1("c0_fail_pass", pass0, 1'b0);
    chk1("c0_fail_done", done0, 1'b1);

    chk1("x_seen1", x1, 1'b0);
    chk1("x_seen3", x3, 1'b0);
    chk1("x_seen100", x100, 1'b0);
    chk1("x_seen0", x0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
